// File: rtl/trivium_seq.sv
// rtl/trivium_seq.sv - Key/data sequencer and output FIFO for a Trivium keystream core
module trivium_seq #(
    parameter int KEY_BITS     = 80,
    parameter int BURST_LEN    = 256,
    parameter int OBUF_DEPTH   = 32,
    parameter int INIT_TIMEOUT = 4095
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [7:0]          din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [7:0]          dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                core_key,
    output logic                core_strob_key,
    output logic [7:0]          core_data,
    output logic                core_strob_data,
    output logic [1:0]          core_fifo_cnd,
    input  logic [7:0]          core_stream,
    input  logic                core_wt_sgn,
    input  logic [7:0]          core_sign,
    output logic                busy,
    output logic                err,
    output logic                ovf
);

    localparam int AW = $clog2(OBUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(KEY_BITS);
    localparam int LW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(INIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_KEY, S_RELEASE, S_WAIT_INIT, S_WAIT_DATA, S_SEND, S_BURST
    } state_t;

    state_t                state_q, state_d;
    logic [KEY_BITS-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [LW-1:0]         burst_q, burst_d;
    logic [7:0]            core_data_q, core_data_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [1:0]            fifo_cnd_q, fifo_cnd_d;
    logic [7:0]            mem_q [OBUF_DEPTH];
    logic [7:0]            mem_d [OBUF_DEPTH];

    logic abort;
    logic push_req;
    logic push_ok;
    logic pop;
    logic full;
    logic unused_sign;

    assign unused_sign = ^{core_sign[7], core_sign[4:3], core_sign[1:0]};
    assign abort       = (state_q != S_IDLE) && (core_sign[5] || core_sign[6]);
    assign full        = (count_q == CW'(OBUF_DEPTH));
    assign pop         = (count_q != '0) && dout_ready;

    always_comb begin
        state_d         = state_q;
        shreg_d         = shreg_q;
        bit_cnt_d       = bit_cnt_q;
        tmo_d           = tmo_q;
        burst_d         = burst_q;
        core_data_d     = core_data_q;
        err_d           = err_q;
        ovf_d           = ovf_q;
        key_ready       = 1'b0;
        din_ready       = 1'b0;
        core_strob_key  = 1'b0;
        core_strob_data = 1'b0;
        push_req        = 1'b0;

        case (state_q)
            S_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    shreg_d   = key_in;
                    err_d     = 1'b0;
                    ovf_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_LOAD_KEY;
                end
            end
            S_LOAD_KEY: begin
                core_strob_key = 1'b1;
                shreg_d        = {shreg_q[KEY_BITS-2:0], 1'b0};
                bit_cnt_d      = bit_cnt_q + BW'(1);
                if (bit_cnt_q == BW'(KEY_BITS - 1)) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                tmo_d   = '0;
                state_d = S_WAIT_INIT;
            end
            S_WAIT_INIT: begin
                tmo_d = tmo_q + TW'(1);
                if (core_sign[2]) begin
                    state_d = S_WAIT_DATA;
                end else if (tmo_d == TW'(INIT_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    core_data_d = din;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                core_strob_data = 1'b1;
                burst_d         = '0;
                state_d         = S_BURST;
            end
            S_BURST: begin
                push_req = core_wt_sgn;
                // Dropped bytes still count toward the burst length.
                if (core_wt_sgn) begin
                    burst_d = burst_q + LW'(1);
                    if (burst_d == LW'(BURST_LEN)) begin
                        state_d = S_WAIT_DATA;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            err_d           = 1'b1;
            state_d         = S_IDLE;
            core_strob_key  = 1'b0;
            core_strob_data = 1'b0;
        end

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = push_req && (!full || pop);
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = core_stream;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        fifo_cnd_d = {full, (count_q >= CW'(OBUF_DEPTH / 2))};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            burst_q     <= '0;
            core_data_q <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_cnd_q  <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            burst_q     <= burst_d;
            core_data_q <= core_data_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_cnd_q  <= fifo_cnd_d;
        end
    end

    // Storage needs no reset: the count gates everything read out of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout          = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign dout_valid    = (count_q != '0);
    assign core_key      = core_strob_key & shreg_q[KEY_BITS-1];
    assign core_data     = core_data_q;
    assign core_fifo_cnd = fifo_cnd_q;
    assign busy          = (state_q != S_IDLE);
    assign err           = err_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_trivium_seq.sv
// tb/tb_trivium_seq.sv - Scoreboard bench for trivium_seq with a scripted core model
module tb_trivium_seq;

    localparam int KEY_BITS     = 80;
    localparam int BURST_LEN    = 256;
    localparam int OBUF_DEPTH   = 32;
    localparam int INIT_TIMEOUT = 4095;

    logic                clk = 1'b0;
    logic                rst;
    logic [KEY_BITS-1:0] key_in;
    logic                key_valid;
    logic                key_ready;
    logic [7:0]          din;
    logic                din_valid;
    logic                din_ready;
    logic [7:0]          dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                core_key;
    logic                core_strob_key;
    logic [7:0]          core_data;
    logic                core_strob_data;
    logic [1:0]          core_fifo_cnd;
    logic [7:0]          core_stream;
    logic                core_wt_sgn;
    logic [7:0]          core_sign;
    logic                busy;
    logic                err;
    logic                ovf;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    trivium_seq #(
        .KEY_BITS(KEY_BITS), .BURST_LEN(BURST_LEN),
        .OBUF_DEPTH(OBUF_DEPTH), .INIT_TIMEOUT(INIT_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .core_key(core_key), .core_strob_key(core_strob_key),
        .core_data(core_data), .core_strob_data(core_strob_data),
        .core_fifo_cnd(core_fifo_cnd), .core_stream(core_stream),
        .core_wt_sgn(core_wt_sgn), .core_sign(core_sign),
        .busy(busy), .err(err), .ovf(ovf)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic accept_key(input logic [KEY_BITS-1:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_release();
        int n = 0;
        while (core_strob_key === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_release: strob_key still high after %0d cycles, want low", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        checks++;
        if ({key_ready, busy, din_ready, dout_valid, core_strob_key, core_strob_data,
             core_key, err, ovf, core_fifo_cnd} !== 11'b100_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got kr=%b busy=%b dr=%b dv=%b sk=%b sd=%b ck=%b err=%b ovf=%b cnd=%b, want kr=1 others 0",
                     key_ready, busy, din_ready, dout_valid, core_strob_key, core_strob_data,
                     core_key, err, ovf, core_fifo_cnd);
        end
        checks++;
        if (dout !== 8'h00 || core_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got dout=%h core_data=%h, want 00 00", dout, core_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_key();
        int   n = 0;
        logic exp_bit;
        accept_key(80'h8000_0000_0000_0000_0001);
        while (core_strob_key === 1'b1 && n < 200) begin
            exp_bit = (n == 0 || n == KEY_BITS - 1);
            checks++;
            if (core_key !== exp_bit) begin
                errors++;
                $display("FAIL key_bit[%0d]: got %b want %b", n, core_key, exp_bit);
            end
            n++;
            tick();
        end
        checks++;
        if (n != KEY_BITS) begin
            errors++;
            $display("FAIL strob_key_len: got %0d want %0d", n, KEY_BITS);
        end
        checks++;
        if (busy !== 1'b1 || core_strob_key !== 1'b0) begin
            errors++;
            $display("FAIL release: got busy=%b sk=%b want 1 0", busy, core_strob_key);
        end
    endtask

    task automatic test_encrypt();
        int sent  = 0;
        int guard = 0;
        repeat (1152) tick();
        checks++;
        if (din_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_init: got dr=%b busy=%b want 0 1", din_ready, busy);
        end
        core_sign = 8'h04;
        tick();
        core_sign = 8'h00;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_data: got dr=%b want 1", din_ready);
        end
        din = 8'h5A;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din = 8'hA5;
        checks++;
        if (core_strob_data !== 1'b1 || core_data !== 8'h5A) begin
            errors++;
            $display("FAIL send: got sd=%b data=%h want 1 5a", core_strob_data, core_data);
        end
        tick();
        checks++;
        if (core_strob_data !== 1'b0 || core_data !== 8'h5A) begin
            errors++;
            $display("FAIL send_pulse: got sd=%b data=%h want 0 5a", core_strob_data, core_data);
        end
        dout_ready = 1'b1;
        while ((sent < BURST_LEN || exp_q.size() > 0) && guard < 2000) begin
            if (dout_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL burst_pop: got %h want nothing", dout);
                end else if (dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL burst_pop: got %h want %h", dout, exp_q[0]);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (sent < BURST_LEN && $urandom_range(0, 3) != 0) begin
                core_wt_sgn = 1'b1;
                core_stream = 8'(sent * 7 + 3);
                exp_q.push_back(core_stream);
                sent++;
            end else begin
                core_wt_sgn = 1'b0;
            end
            tick();
            guard++;
        end
        core_wt_sgn = 1'b0;
        checks++;
        if (guard >= 2000 || din_ready !== 1'b1 || ovf !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: got guard=%0d dr=%b ovf=%b dv=%b want <2000 1 0 0",
                     guard, din_ready, ovf, dout_valid);
        end
    endtask

    task automatic test_overflow();
        int g = 0;
        dout_ready = 1'b0;
        din = 8'hC3;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        for (int i = 0; i < BURST_LEN; i++) begin
            if (i == OBUF_DEPTH) begin
                checks++;
                if (ovf !== 1'b0 || core_fifo_cnd !== 2'b01) begin
                    errors++;
                    $display("FAIL fill_edge: got ovf=%b cnd=%b want 0 01", ovf, core_fifo_cnd);
                end
            end
            core_wt_sgn = 1'b1;
            core_stream = 8'(i) ^ 8'h96;
            if (i < OBUF_DEPTH) exp_q.push_back(core_stream);
            tick();
        end
        core_wt_sgn = 1'b0;
        checks++;
        if (din_ready !== 1'b1 || ovf !== 1'b1 || core_fifo_cnd !== 2'b11 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got dr=%b ovf=%b cnd=%b dv=%b want 1 1 11 1",
                     din_ready, ovf, core_fifo_cnd, dout_valid);
        end
        for (int i = 0; i < OBUF_DEPTH / 2; i++) begin
            dout_ready = 1'b1;
            checks++;
            if (dout !== exp_q[0]) begin
                errors++;
                $display("FAIL ovf_pop[%0d]: got %h want %h", i, dout, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        dout_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (core_fifo_cnd !== 2'b01) begin
            errors++;
            $display("FAIL cnd_half: got %b want 01", core_fifo_cnd);
        end
        dout_ready = 1'b1;
        void'(exp_q.pop_front());
        tick();
        dout_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (core_fifo_cnd !== 2'b00) begin
            errors++;
            $display("FAIL cnd_low: got %b want 00", core_fifo_cnd);
        end
        dout_ready = 1'b1;
        while (exp_q.size() > 0 && g < 100) begin
            if (dout_valid === 1'b1) begin
                checks++;
                if (dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL ovf_drain: got %h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            tick();
            g++;
        end
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_empty: got dv=%b left=%0d want 0 0", dout_valid, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int g = 0;
        din = 8'h33;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            core_wt_sgn = 1'b1;
            core_stream = 8'h10 + 8'(i);
            exp_q.push_back(core_stream);
            tick();
        end
        core_wt_sgn = 1'b0;
        core_sign = 8'h40;
        tick();
        core_sign = 8'h00;
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort: got busy=%b err=%b kr=%b want 0 1 1", busy, err, key_ready);
        end
        for (int i = 0; i < 3; i++) begin
            core_wt_sgn = (i < 2);
            core_stream = 8'hEE;
            tick();
            checks++;
            if (core_strob_key !== 1'b0 || core_strob_data !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: got sk=%b sd=%b busy=%b want 0 0 0",
                         i, core_strob_key, core_strob_data, busy);
            end
        end
        core_wt_sgn = 1'b0;
        dout_ready = 1'b1;
        while (exp_q.size() > 0 && g < 50) begin
            if (dout_valid === 1'b1) begin
                checks++;
                if (dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL abort_keep: got %h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            tick();
            g++;
        end
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_empty: got dv=%b left=%0d want 0 0", dout_valid, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        checks++;
        if (err !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sticky: got err=%b ovf=%b want 1 1", err, ovf);
        end
        accept_key(80'h1234_5678_9ABC_DEF0_1357);
        checks++;
        if (err !== 1'b0 || ovf !== 1'b0 || core_strob_key !== 1'b1) begin
            errors++;
            $display("FAIL key_clear: got err=%b ovf=%b sk=%b want 0 0 1", err, ovf, core_strob_key);
        end
        wait_release();
        while (busy === 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (n != INIT_TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_len: got %0d want %0d", n, INIT_TIMEOUT + 1);
        end
        checks++;
        if (err !== 1'b1 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flags: got err=%b kr=%b want 1 1", err, key_ready);
        end
    endtask

    task automatic test_reset_mid();
        accept_key(80'hFFFF_0000_FFFF_0000_FFFF);
        wait_release();
        repeat (3) tick();
        core_sign = 8'h04;
        tick();
        core_sign = 8'h00;
        din = 8'h77;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            core_wt_sgn = 1'b1;
            core_stream = 8'hB0 + 8'(i);
            tick();
        end
        core_wt_sgn = 1'b0;
        core_sign = 8'h20;
        tick();
        core_sign = 8'h00;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_bit5: got err=%b busy=%b want 1 0", err, busy);
        end
        accept_key(80'h0F0F_0F0F_0F0F_0F0F_0F0F);
        repeat (9) tick();
        checks++;
        if (core_strob_key !== 1'b1 || dout_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got sk=%b dv=%b busy=%b want 1 1 1", core_strob_key, dout_valid, busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (core_strob_key !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || dout_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got sk=%b busy=%b kr=%b dv=%b err=%b want 0 0 1 0 0",
                     core_strob_key, busy, key_ready, dout_valid, err);
        end
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        checks++;
        if (key_ready !== 1'b1 || core_fifo_cnd !== 2'b00 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got kr=%b cnd=%b dv=%b want 1 00 0", key_ready, core_fifo_cnd, dout_valid);
        end
    endtask

    initial begin
        rst         = 1'b0;
        key_in      = '0;
        key_valid   = 1'b0;
        din         = 8'h00;
        din_valid   = 1'b0;
        dout_ready  = 1'b0;
        core_stream = 8'h00;
        core_wt_sgn = 1'b0;
        core_sign   = 8'h00;
        test_reset();
        test_load_key();
        test_encrypt();
        test_overflow();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
